// File: rtl/memory_arbiter_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory arbiter slice.
//   ADDR_W / DATA_W   : request, address-line and data widths
//   MEM_DEPTH_DEF     : default number of implemented memory words
//   state_e           : arbiter sequencer states (IDLE, ISSUE)
//   req_id_e          : requester identity (REQ_FETCH, REQ_DATA)
//   cmd_t             : command register latched at grant time
//   addr_in_range()   : true when an address falls inside the implemented words
package mem_arb_pkg;

  localparam int unsigned ADDR_W        = 16;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned MEM_DEPTH_DEF = 1024;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  typedef struct packed {
    req_id_e             id;
    logic                write;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } cmd_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned       depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: bundles the requester handshakes and the memory bank bus.
//   Fetch*   : instruction-fetch read port (req/addr in, gnt/data/valid out)
//   Data*    : load/store port (req/write/addr/wdata in, gnt/rdata/valid/err out)
//   AddressLine, MEMWriteBus, WriteMEM : arbiter-driven memory controls
//   MEMReadBus                         : combinational read data from memory
// Modports: slave = arbiter view, master = requesters + memory view.
interface memory_arbiter_if #(
  parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_arb_pkg::DATA_W
);

  logic              FetchReq;
  logic [ADDR_W-1:0] FetchAddr;
  logic              FetchGnt;
  logic [DATA_W-1:0] FetchData;
  logic              FetchValid;

  logic              DataReq;
  logic              DataWrite;
  logic [ADDR_W-1:0] DataAddr;
  logic [DATA_W-1:0] DataWData;
  logic              DataGnt;
  logic [DATA_W-1:0] DataRData;
  logic              DataValid;
  logic              DataErr;

  logic [ADDR_W-1:0] AddressLine;
  logic [DATA_W-1:0] MEMWriteBus;
  logic              WriteMEM;
  logic [DATA_W-1:0] MEMReadBus;

  modport slave (
    input  FetchReq, FetchAddr,
    output FetchGnt, FetchData, FetchValid,
    input  DataReq, DataWrite, DataAddr, DataWData,
    output DataGnt, DataRData, DataValid, DataErr,
    output AddressLine, MEMWriteBus, WriteMEM,
    input  MEMReadBus
  );

  modport master (
    output FetchReq, FetchAddr,
    input  FetchGnt, FetchData, FetchValid,
    output DataReq, DataWrite, DataAddr, DataWData,
    input  DataGnt, DataRData, DataValid, DataErr,
    input  AddressLine, MEMWriteBus, WriteMEM,
    output MEMReadBus
  );

endinterface

// File: rtl/memory_arbiter_select.sv
// mem_arb_select: combinational two-way winner picker.
//   fetch_req, data_req : pending requests
//   win_id / win_valid  : chosen requester and "someone is requesting"
// Build option ARB_ROUND_ROBIN_EN: adds clk/rst_n/upd ports and a last-grant
// pointer so ties alternate; otherwise data always wins a tie.
module mem_arb_select
  import mem_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic    clk,
  input  logic    rst_n,
  input  logic    upd,
`endif
  input  logic    fetch_req,
  input  logic    data_req,
  output req_id_e win_id,
  output logic    win_valid
);

  assign win_valid = fetch_req | data_req;

`ifdef ARB_ROUND_ROBIN_EN
  req_id_e last_q, last_d;

  always_comb begin
    if (fetch_req && data_req) begin
      win_id = (last_q == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
    end else begin
      win_id = data_req ? REQ_DATA : REQ_FETCH;
    end
  end

  assign last_d = upd ? win_id : last_q;

  // Starts as "fetch last" so data takes the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= REQ_FETCH;
    else        last_q <= last_d;
  end
`else
  assign win_id = data_req ? REQ_DATA : REQ_FETCH;
`endif

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates fetch and load/store requests onto a single-port
// memory, one access per two cycles (IDLE grant, ISSUE access), and returns
// registered read data with a one-cycle Valid strobe the cycle after ISSUE.
// Ports:
//   ClockInput : rising-edge clock
//   ResetInput : asynchronous active-low reset
//   bus        : memory_arbiter_if.slave (requester handshakes + memory bus)
// Build option ARB_ROUND_ROBIN_EN selects round-robin tie breaking instead of
// fixed data-over-fetch priority.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic            ClockInput,
  input  logic            ResetInput,
  memory_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fetch_vld_q, fetch_vld_d;
  logic              data_vld_q, data_vld_d;
  logic              err_q, err_d;

  req_id_e           win_id;
  logic              win_valid;
  logic              grant;
  logic              issuing;
  logic              cmd_in_range;

  mem_arb_select u_select (
`ifdef ARB_ROUND_ROBIN_EN
    .clk       (ClockInput),
    .rst_n     (ResetInput),
    .upd       (grant),
`endif
    .fetch_req (bus.FetchReq),
    .data_req  (bus.DataReq),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  // Grants only come out of IDLE; requests seen during ISSUE simply wait.
  assign grant        = (state_q == IDLE) && win_valid;
  assign bus.FetchGnt = grant && (win_id == REQ_FETCH);
  assign bus.DataGnt  = grant && (win_id == REQ_DATA);

  assign issuing      = (state_q == ISSUE);
  assign cmd_in_range = addr_in_range(cmd_q.addr, MEM_DEPTH);

  // Decoded from the async-reset state flop, so WriteMEM drops the moment
  // reset asserts and an in-flight store never reaches the memory edge.
  assign bus.AddressLine = issuing ? cmd_q.addr : '0;
  assign bus.WriteMEM    = issuing && cmd_q.write && cmd_in_range;
  assign bus.MEMWriteBus = bus.WriteMEM ? cmd_q.wdata : '0;

  assign bus.FetchData  = rdata_q;
  assign bus.DataRData  = rdata_q;
  assign bus.FetchValid = fetch_vld_q;
  assign bus.DataValid  = data_vld_q;
  assign bus.DataErr    = err_q;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rdata_d     = rdata_q;
    fetch_vld_d = 1'b0;
    data_vld_d  = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d  = ISSUE;
          cmd_d.id = win_id;
          if (win_id == REQ_DATA) begin
            cmd_d.write = bus.DataWrite;
            cmd_d.addr  = bus.DataAddr;
            cmd_d.wdata = bus.DataWData;
          end else begin
            // Fetch is read-only; DataWrite is never consulted for it.
            cmd_d.write = 1'b0;
            cmd_d.addr  = bus.FetchAddr;
            cmd_d.wdata = '0;
          end
        end
      end
      ISSUE: begin
        state_d     = IDLE;
        // Stores and out-of-range accesses report zero data.
        rdata_d     = (!cmd_q.write && cmd_in_range) ? bus.MEMReadBus : '0;
        fetch_vld_d = (cmd_q.id == REQ_FETCH);
        data_vld_d  = (cmd_q.id == REQ_DATA);
        err_d       = (cmd_q.id == REQ_DATA) && !cmd_in_range;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ClockInput or negedge ResetInput) begin
    if (!ResetInput) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rdata_q     <= '0;
      fetch_vld_q <= 1'b0;
      data_vld_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rdata_q     <= rdata_d;
      fetch_vld_q <= fetch_vld_d;
      data_vld_q  <= data_vld_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed testbench for memory_arbiter with a behavioural
// single-port memory (combinational read, write on the rising edge).
// Honours ARB_ROUND_ROBIN_EN for the tie-breaking expectations.
module tb_memory_arbiter;

  logic ClockInput;
  logic ResetInput;

  memory_arbiter_if bus ();

  memory_arbiter u_dut (
    .ClockInput (ClockInput),
    .ResetInput (ResetInput),
    .bus        (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  initial ClockInput = 1'b0;
  always #5 ClockInput = ~ClockInput;

  // Memory model: unwritten words read a fixed pattern (A000 | addr), word 3 = 1026.
  logic [15:0]   mem_q [0:1023];
  logic [1023:0] written = '0;

  function automatic logic [15:0] mem_word(input logic [9:0] a);
    if (written[a]) return mem_q[a];
    if (a == 10'd3) return 16'h1026;
    return 16'hA000 | {6'd0, a};
  endfunction

  assign bus.MEMReadBus = (bus.AddressLine < 16'd1024) ? mem_word(bus.AddressLine[9:0]) : 16'hDEAD;

  always @(posedge ClockInput) begin
    if (bus.WriteMEM) begin
      mem_q[bus.AddressLine[9:0]]   <= bus.MEMWriteBus;
      written[bus.AddressLine[9:0]] <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge ClockInput);
    #1;
  endtask

  task automatic test_reset();
    @(negedge ClockInput);
    vectors++;
    if ({bus.FetchGnt, bus.DataGnt, bus.FetchValid, bus.DataValid, bus.DataErr, bus.WriteMEM} !== 6'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b want 000000", {bus.FetchGnt, bus.DataGnt, bus.FetchValid, bus.DataValid, bus.DataErr, bus.WriteMEM});
    end
    vectors++;
    if ({bus.FetchData, bus.DataRData, bus.AddressLine, bus.MEMWriteBus} !== 64'b0) begin
      miscompares++; $display("FAIL reset_data: got %h want 0", {bus.FetchData, bus.DataRData, bus.AddressLine, bus.MEMWriteBus});
    end
    tick();
    ResetInput = 1'b1;
    @(negedge ClockInput);
    vectors++;
    if ({bus.FetchGnt, bus.DataGnt, bus.FetchValid, bus.DataValid, bus.WriteMEM} !== 5'b0) begin
      miscompares++; $display("FAIL post_reset_idle: got %b want 00000", {bus.FetchGnt, bus.DataGnt, bus.FetchValid, bus.DataValid, bus.WriteMEM});
    end
    tick();
  endtask

  task automatic test_fetch();
    bus.FetchReq = 1'b1; bus.FetchAddr = 16'd3; bus.DataWrite = 1'b1;  // DataWrite must not matter
    @(negedge ClockInput);
    vectors++;
    if ({bus.FetchGnt, bus.DataGnt, bus.WriteMEM} !== 3'b100) begin
      miscompares++; $display("FAIL fetch_gnt: got %b want 100", {bus.FetchGnt, bus.DataGnt, bus.WriteMEM});
    end
    tick();
    bus.FetchReq = 1'b0; bus.DataWrite = 1'b0;
    @(negedge ClockInput);
    vectors++;
    if (bus.AddressLine !== 16'd3 || bus.WriteMEM !== 1'b0 || bus.FetchGnt !== 1'b0) begin
      miscompares++; $display("FAIL fetch_issue: got addr=%0d we=%b gnt=%b want addr=3 we=0 gnt=0", bus.AddressLine, bus.WriteMEM, bus.FetchGnt);
    end
    tick();
    @(negedge ClockInput);
    vectors++;
    if (bus.FetchValid !== 1'b1 || bus.FetchData !== 16'h1026 || bus.DataValid !== 1'b0) begin
      miscompares++; $display("FAIL fetch_resp: got v=%b d=%h dv=%b want v=1 d=1026 dv=0", bus.FetchValid, bus.FetchData, bus.DataValid);
    end
    tick();
    @(negedge ClockInput);
    vectors++;
    if (bus.FetchValid !== 1'b0) begin
      miscompares++; $display("FAIL fetch_valid_pulse: got %b want 0", bus.FetchValid);
    end
    tick();
  endtask

  task automatic test_arbitration();
    logic [1:0] exp;
    logic [1:0] prev;
    prev = 2'b00;
    bus.FetchReq = 1'b1; bus.FetchAddr = 16'd3;
    bus.DataReq = 1'b1; bus.DataWrite = 1'b0; bus.DataAddr = 16'd5;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;  // {FetchGnt, DataGnt}: D, F, D, F
`else
      exp = 2'b01;                          // data always wins
`endif
      @(negedge ClockInput);
      vectors++;
      if ({bus.FetchGnt, bus.DataGnt} !== exp) begin
        miscompares++; $display("FAIL arb_gnt_%0d: got %b want %b", i, {bus.FetchGnt, bus.DataGnt}, exp);
      end
      vectors++;
      if ({bus.FetchValid, bus.DataValid} !== prev) begin
        miscompares++; $display("FAIL arb_valid_%0d: got %b want %b", i, {bus.FetchValid, bus.DataValid}, prev);
      end
      tick();
      if (i == 3) begin bus.FetchReq = 1'b0; bus.DataReq = 1'b0; end
      @(negedge ClockInput);
      vectors++;
      if ({bus.FetchGnt, bus.DataGnt} !== 2'b00) begin
        miscompares++; $display("FAIL arb_issue_nogrant_%0d: got %b want 00", i, {bus.FetchGnt, bus.DataGnt});
      end
      prev = exp;
      tick();
    end
    @(negedge ClockInput);
    vectors++;
    if ({bus.FetchValid, bus.DataValid} !== prev) begin
      miscompares++; $display("FAIL arb_valid_last: got %b want %b", {bus.FetchValid, bus.DataValid}, prev);
    end
    tick();
  endtask

  task automatic test_store_load();
    bus.DataReq = 1'b1; bus.DataWrite = 1'b1; bus.DataAddr = 16'd210; bus.DataWData = 16'd57;
    @(negedge ClockInput);
    vectors++;
    if ({bus.FetchGnt, bus.DataGnt} !== 2'b01) begin
      miscompares++; $display("FAIL store_gnt: got %b want 01", {bus.FetchGnt, bus.DataGnt});
    end
    tick();
    bus.DataReq = 1'b0;
    @(negedge ClockInput);
    vectors++;
    if (bus.WriteMEM !== 1'b1 || bus.MEMWriteBus !== 16'd57 || bus.AddressLine !== 16'd210) begin
      miscompares++; $display("FAIL store_issue: got we=%b wd=%0d a=%0d want we=1 wd=57 a=210", bus.WriteMEM, bus.MEMWriteBus, bus.AddressLine);
    end
    tick();
    bus.DataReq = 1'b1; bus.DataWrite = 1'b0; bus.DataAddr = 16'd210; bus.DataWData = 16'hFFFF;
    @(negedge ClockInput);
    vectors++;
    if (bus.WriteMEM !== 1'b0 || bus.DataValid !== 1'b1 || bus.DataRData !== 16'd0 || bus.DataErr !== 1'b0) begin
      miscompares++; $display("FAIL store_resp: got we=%b v=%b d=%h e=%b want we=0 v=1 d=0000 e=0", bus.WriteMEM, bus.DataValid, bus.DataRData, bus.DataErr);
    end
    vectors++;
    if (bus.DataGnt !== 1'b1 || mem_word(10'd210) !== 16'd57) begin
      miscompares++; $display("FAIL load_gnt_with_valid: got gnt=%b mem=%h want gnt=1 mem=0039", bus.DataGnt, mem_word(10'd210));
    end
    tick();
    bus.DataReq = 1'b0;
    @(negedge ClockInput);
    vectors++;
    if (bus.WriteMEM !== 1'b0 || bus.AddressLine !== 16'd210) begin
      miscompares++; $display("FAIL load_issue: got we=%b a=%0d want we=0 a=210", bus.WriteMEM, bus.AddressLine);
    end
    tick();
    @(negedge ClockInput);
    vectors++;
    if (bus.DataValid !== 1'b1 || bus.DataRData !== 16'd57 || bus.DataErr !== 1'b0) begin
      miscompares++; $display("FAIL load_resp: got v=%b d=%0d e=%b want v=1 d=57 e=0", bus.DataValid, bus.DataRData, bus.DataErr);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    bus.DataReq = 1'b1; bus.DataWrite = 1'b0; bus.DataAddr = 16'd1024;
    @(negedge ClockInput);
    vectors++;
    if (bus.DataGnt !== 1'b1) begin
      miscompares++; $display("FAIL oor_load_gnt: got %b want 1", bus.DataGnt);
    end
    tick();
    bus.DataReq = 1'b0;
    @(negedge ClockInput);
    vectors++;
    if (bus.AddressLine !== 16'd1024 || bus.WriteMEM !== 1'b0) begin
      miscompares++; $display("FAIL oor_load_issue: got a=%0d we=%b want a=1024 we=0", bus.AddressLine, bus.WriteMEM);
    end
    tick();
    bus.DataReq = 1'b1; bus.DataWrite = 1'b1; bus.DataAddr = 16'd1100; bus.DataWData = 16'hBEEF;
    @(negedge ClockInput);
    vectors++;
    if (bus.DataValid !== 1'b1 || bus.DataErr !== 1'b1 || bus.DataRData !== 16'd0 || bus.DataGnt !== 1'b1) begin
      miscompares++; $display("FAIL oor_load_resp: got v=%b e=%b d=%h g=%b want v=1 e=1 d=0000 g=1", bus.DataValid, bus.DataErr, bus.DataRData, bus.DataGnt);
    end
    tick();
    bus.DataReq = 1'b0; bus.DataWrite = 1'b0;
    @(negedge ClockInput);
    vectors++;
    if (bus.WriteMEM !== 1'b0 || bus.MEMWriteBus !== 16'd0) begin
      miscompares++; $display("FAIL oor_store_nowrite: got we=%b wd=%h want we=0 wd=0000", bus.WriteMEM, bus.MEMWriteBus);
    end
    tick();
    bus.FetchReq = 1'b1; bus.FetchAddr = 16'd2000;
    @(negedge ClockInput);
    vectors++;
    if (bus.DataValid !== 1'b1 || bus.DataErr !== 1'b1 || bus.DataRData !== 16'd0 || bus.FetchGnt !== 1'b1) begin
      miscompares++; $display("FAIL oor_store_resp: got v=%b e=%b d=%h fg=%b want v=1 e=1 d=0000 fg=1", bus.DataValid, bus.DataErr, bus.DataRData, bus.FetchGnt);
    end
    tick();
    bus.FetchReq = 1'b0;
    @(negedge ClockInput);
    vectors++;
    if (bus.DataErr !== 1'b0 || bus.DataValid !== 1'b0) begin
      miscompares++; $display("FAIL oor_err_pulse: got e=%b v=%b want e=0 v=0", bus.DataErr, bus.DataValid);
    end
    tick();
    @(negedge ClockInput);
    vectors++;
    if (bus.FetchValid !== 1'b1 || bus.FetchData !== 16'd0 || bus.DataErr !== 1'b0 || mem_word(10'd76) !== 16'hA04C) begin
      miscompares++; $display("FAIL oor_fetch_resp: got v=%b d=%h e=%b mem76=%h want v=1 d=0000 e=0 mem76=a04c", bus.FetchValid, bus.FetchData, bus.DataErr, mem_word(10'd76));
    end
    tick();
  endtask

  task automatic test_req_during_issue();
    bus.FetchReq = 1'b1; bus.FetchAddr = 16'd5;
    @(negedge ClockInput);
    vectors++;
    if (bus.FetchGnt !== 1'b1) begin
      miscompares++; $display("FAIL rdi_fetch_gnt: got %b want 1", bus.FetchGnt);
    end
    tick();
    bus.FetchReq = 1'b0;
    bus.DataReq = 1'b1; bus.DataWrite = 1'b0; bus.DataAddr = 16'd210;
    @(negedge ClockInput);
    vectors++;
    if ({bus.FetchGnt, bus.DataGnt} !== 2'b00) begin
      miscompares++; $display("FAIL rdi_no_gnt_in_issue: got %b want 00", {bus.FetchGnt, bus.DataGnt});
    end
    tick();
    @(negedge ClockInput);
    vectors++;
    if (bus.DataGnt !== 1'b1 || bus.FetchValid !== 1'b1 || bus.FetchData !== 16'hA005) begin
      miscompares++; $display("FAIL rdi_gnt_next_idle: got g=%b fv=%b fd=%h want g=1 fv=1 fd=a005", bus.DataGnt, bus.FetchValid, bus.FetchData);
    end
    tick();
    bus.DataReq = 1'b0;
    tick();
    @(negedge ClockInput);
    vectors++;
    if (bus.DataValid !== 1'b1 || bus.DataRData !== 16'd57) begin
      miscompares++; $display("FAIL rdi_load_resp: got v=%b d=%0d want v=1 d=57", bus.DataValid, bus.DataRData);
    end
    tick();
  endtask

  task automatic test_reset_mid_issue();
    bus.DataReq = 1'b1; bus.DataWrite = 1'b1; bus.DataAddr = 16'd300; bus.DataWData = 16'h5555;
    @(negedge ClockInput);
    vectors++;
    if (bus.DataGnt !== 1'b1) begin
      miscompares++; $display("FAIL rst_store_gnt: got %b want 1", bus.DataGnt);
    end
    tick();
    bus.DataReq = 1'b0; bus.DataWrite = 1'b0;
    #1;
    vectors++;
    if (bus.WriteMEM !== 1'b1) begin
      miscompares++; $display("FAIL rst_store_issue: got we=%b want 1", bus.WriteMEM);
    end
    ResetInput = 1'b0;
    #1;
    vectors++;
    if (bus.WriteMEM !== 1'b0 || bus.AddressLine !== 16'd0 || bus.MEMWriteBus !== 16'd0) begin
      miscompares++; $display("FAIL rst_async_drop: got we=%b a=%h wd=%h want 0 0000 0000", bus.WriteMEM, bus.AddressLine, bus.MEMWriteBus);
    end
    tick();
    vectors++;
    if (mem_word(10'd300) !== 16'hA12C) begin
      miscompares++; $display("FAIL rst_word_unchanged: got %h want a12c", mem_word(10'd300));
    end
    @(negedge ClockInput);
    ResetInput = 1'b1;
    tick();
    @(negedge ClockInput);
    vectors++;
    if ({bus.FetchGnt, bus.DataGnt, bus.FetchValid, bus.DataValid, bus.DataErr, bus.WriteMEM} !== 6'b0 ||
        {bus.FetchData, bus.DataRData, bus.AddressLine, bus.MEMWriteBus} !== 64'b0) begin
      miscompares++; $display("FAIL rst_release_outputs: got ctrl=%b data=%h want all zero",
        {bus.FetchGnt, bus.DataGnt, bus.FetchValid, bus.DataValid, bus.DataErr, bus.WriteMEM},
        {bus.FetchData, bus.DataRData, bus.AddressLine, bus.MEMWriteBus});
    end
    tick();
    bus.FetchReq = 1'b1; bus.FetchAddr = 16'd3;
    @(negedge ClockInput);
    vectors++;
    if (bus.FetchGnt !== 1'b1) begin
      miscompares++; $display("FAIL rst_next_gnt: got %b want 1", bus.FetchGnt);
    end
    tick();
    bus.FetchReq = 1'b0;
    tick();
    @(negedge ClockInput);
    vectors++;
    if (bus.FetchValid !== 1'b1 || bus.FetchData !== 16'h1026) begin
      miscompares++; $display("FAIL rst_next_resp: got v=%b d=%h want v=1 d=1026", bus.FetchValid, bus.FetchData);
    end
    tick();
  endtask

  initial begin
    ResetInput    = 1'b0;
    bus.FetchReq  = 1'b0;
    bus.FetchAddr = '0;
    bus.DataReq   = 1'b0;
    bus.DataWrite = 1'b0;
    bus.DataAddr  = '0;
    bus.DataWData = '0;

    test_reset();
    test_fetch();
    test_arbitration();
    test_store_load();
    test_out_of_range();
    test_req_during_issue();
    test_reset_mid_issue();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester arbiter and sequencer for the shared single-port 16-bit data/code memory. The instruction-fetch unit and the load/store unit each request accesses, and the arbiter grants one per access slot. It drives the memory's address, write-data and write-enable lines, then returns registered read data with a response strobe to the winner. It sits between the CPU core and the memory bank; the memory has a combinational read and a write on the clock edge.

## Interface
- ADDR_W, 16, address width of requests and of AddressLine
- DATA_W, 16, data width
- MEM_DEPTH, 1024, number of implemented words; addresses >= MEM_DEPTH are out of range
- ClockInput  in  1  single clock, rising edge
- ResetInput  in  1  reset, asynchronous, active-low
- FetchReq  in  1  fetch read request, held until FetchGnt
- FetchAddr  in  ADDR_W  fetch address, stable while FetchReq
- FetchGnt  out  1  fetch request accepted this cycle
- FetchData  out  DATA_W  fetch read data, valid with FetchValid
- FetchValid  out  1  one-cycle fetch response strobe
- DataReq  in  1  load/store request, held until DataGnt
- DataWrite  in  1  1 = store, 0 = load; qualified by DataReq
- DataAddr  in  ADDR_W  load/store address
- DataWData  in  DATA_W  store data
- DataGnt  out  1  load/store request accepted this cycle
- DataRData  out  DATA_W  load data, valid with DataValid
- DataValid  out  1  one-cycle load/store response strobe (stores too)
- DataErr  out  1  out-of-range address, qualified by DataValid
- AddressLine  out  ADDR_W  to memory address
- MEMWriteBus  out  DATA_W  to memory write data
- WriteMEM  out  1  to memory write enable
- MEMReadBus  in  DATA_W  from memory read data

## Operation
- States: IDLE, ISSUE. Reset state is IDLE.
- IDLE: if any request is pending, the selector picks a winner. The winner's Gnt is driven combinationally in the same cycle. Opcode, address, write data and requester id are latched into the command register. Next state is ISSUE. With no request pending, the arbiter stays in IDLE.
- ISSUE: AddressLine = latched address. For an in-range store, WriteMEM = 1 and MEMWriteBus = latched data, for this cycle only. For a load or fetch, MEMReadBus is captured at the end of the cycle. Next state is always IDLE.
- Response: in the cycle after ISSUE, the winner's Valid pulses for one cycle with the registered read data. Store responses carry data 0.
- Out of range (address >= MEM_DEPTH): no write is performed, read data = 0, and DataErr = 1 with DataValid. Fetch has no error port: an out-of-range fetch returns 0.
- Outside ISSUE: AddressLine = 0, MEMWriteBus = 0, WriteMEM = 0.
- Both Gnt signals are never high together. No Gnt is issued in ISSUE. Requests arriving during ISSUE wait for the next IDLE.
- Fetch is read-only and ignores DataWrite.
- Reset asserted mid-ISSUE: the state goes to IDLE immediately and WriteMEM drops asynchronously, so the store is abandoned. No Valid is produced for the in-flight access.

## Timing
- Reset values: every output is 0.
- Latency: a request first seen in IDLE at cycle N is granted at N, issued at N+1, and its Valid arrives at N+2.
- Throughput: one access per 2 cycles. A new Gnt may coincide with the previous access's Valid.
- Read data registered from MEMReadBus is held until the next capture. Consumers sample it only with Valid.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin between the two requesters. A last-grant pointer is updated on each Gnt. With both requesting, the requester not granted last wins. After reset, the pointer is set to "fetch last", so data wins the first tie.
- Not defined: fixed priority, Data > Fetch, on every tie. Fetch can starve under continuous data traffic; this is accepted.

## Structure
- Package mem_arb_pkg holds:
  - ADDR_W, DATA_W and MEM_DEPTH defaults
  - state enum {IDLE, ISSUE}
  - requester id enum {REQ_FETCH, REQ_DATA}
  - command-register struct (id, write, addr, wdata)
- Sub-module mem_arb_select: a combinational two-way picker. Inputs are the two requests and the pointer; outputs are a winner id and a valid flag. The pointer flop lives inside it under ARB_ROUND_ROBIN_EN.

## Test plan
- Fetch only, address 3, memory[3] = 16'h1026: FetchGnt at cycle 0, AddressLine = 3 at cycle 1, FetchValid with FetchData = 16'h1026 at cycle 2, WriteMEM never 1.
- Store of 57 to address 210, then a load from 210: WriteMEM = 1 for exactly one cycle with MEMWriteBus = 57. The load returns DataRData = 57 with DataErr = 0.
- Both requesting continuously, macro on: grants alternate D, F, D, F. Macro off: only D is granted while DataReq is held.
- Load from address 1024: DataValid with DataErr = 1 and DataRData = 0. A store to 1100 produces no WriteMEM.
- ResetInput driven low during the ISSUE of a store: WriteMEM falls in the same cycle and the target word is unchanged. After release, all outputs are 0 and the next request is granted from IDLE.
- Requests rising during ISSUE: no Gnt in that cycle; Gnt is issued in the following IDLE cycle.
